fp32_maxmin_ctrl: RTL and testbench

Sequencing controller that finds the maximum and minimum of a length-`i_len` stream of FP32 values using one shared FP32 compare unit. It accepts elements over a valid/ready handshake and issues a GT (op 1) compare against the running max, then an LT (op 3) compare against the running min. It reports the extrema, their first-occurrence indices and a sticky NaN flag. It sits between the stream source and the compare unit, which has a 1-cycle registered result.

---
 rtl/fp32_maxmin_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_fp32_maxmin_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_maxmin_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_maxmin_ctrl
//  Purpose  : Streams i_len FP32 elements over valid/ready, finds the maximum
//             and minimum with one shared external FP32 compare unit (GT then
//             LT per element), and reports the extrema, their first-occurrence
//             indices and sticky NaN / compare-protocol error flags.
//  Ports    :
//    clk, rstn                      clock, synchronous active-low reset
//    i_start, i_len                 job start (IDLE only) and element count
//    i_data_valid, i_data,
//    o_data_ready                   element stream handshake
//    o_busy                         high whenever not IDLE
//    o_cmp_valid, o_cmp_op,
//    o_cmp_a, o_cmp_b               request to the compare unit (1=GT, 3=LT)
//    i_cmp_result_valid,
//    i_cmp_result, i_cmp_nan_err    registered compare-unit response
//    o_done                         one-cycle job completion pulse
//    o_max, o_min,
//    o_max_idx, o_min_idx           extrema and their first indices
//    o_nan_err, o_cmp_err           sticky per-job error flags
//  Revision : 1.0  initial release
// ============================================================================
module fp32_maxmin_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_data_valid,
    input  logic [31:0]      i_data,
    output logic             o_data_ready,
    output logic             o_busy,
    output logic             o_cmp_valid,
    output logic [2:0]       o_cmp_op,
    output logic [31:0]      o_cmp_a,
    output logic [31:0]      o_cmp_b,
    input  logic             i_cmp_result_valid,
    input  logic             i_cmp_result,
    input  logic             i_cmp_nan_err,
    output logic             o_done,
    output logic [31:0]      o_max,
    output logic [31:0]      o_min,
    output logic [LEN_W-1:0] o_max_idx,
    output logic [LEN_W-1:0] o_min_idx,
    output logic             o_nan_err,
    output logic             o_cmp_err
);

    localparam logic [2:0]  C_IDLE     = 3'd0;
    localparam logic [2:0]  C_FETCH    = 3'd1;
    localparam logic [2:0]  C_CMP_MAX  = 3'd2;
    localparam logic [2:0]  C_CMP_MIN  = 3'd3;
    localparam logic [2:0]  C_WAIT_MIN = 3'd4;
    localparam logic [2:0]  C_DONE     = 3'd5;

    localparam logic [2:0]  C_OP_NONE  = 3'd0;
    localparam logic [2:0]  C_OP_GT    = 3'd1;
    localparam logic [2:0]  C_OP_LT    = 3'd3;
    localparam logic [31:0] C_QNAN     = 32'h7FC0_0000;

    logic [2:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_elem;
    logic [LEN_W-1:0] r_elem_idx;
    logic             r_have_ref;
    logic             r_cmp_valid;
    logic [2:0]       r_cmp_op;
    logic [31:0]      r_cmp_a;
    logic [31:0]      r_cmp_b;
    logic [31:0]      r_max;
    logic [31:0]      r_min;
    logic [LEN_W-1:0] r_max_idx;
    logic [LEN_W-1:0] r_min_idx;
    logic             r_nan_err;
    logic             r_cmp_err;

    logic             w_elem_nan;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             w_last_fetch;

    assign w_elem_nan   = (i_data[30:23] == 8'hFF) && (i_data[22:0] != 23'd0);
    assign w_cnt_inc    = r_cnt + LEN_W'(1);
    assign w_last_fetch = (w_cnt_inc == r_len);

    // Ready and busy depend on state only, never on the incoming valid.
    assign o_data_ready = (r_state == C_FETCH);
    assign o_busy       = (r_state != C_IDLE);
    assign o_done       = (r_state == C_DONE);

    assign o_cmp_valid  = r_cmp_valid;
    assign o_cmp_op     = r_cmp_op;
    assign o_cmp_a      = r_cmp_a;
    assign o_cmp_b      = r_cmp_b;
    assign o_max        = r_max;
    assign o_min        = r_min;
    assign o_max_idx    = r_max_idx;
    assign o_min_idx    = r_min_idx;
    assign o_nan_err    = r_nan_err;
    assign o_cmp_err    = r_cmp_err;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= C_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_elem      <= '0;
            r_elem_idx  <= '0;
            r_have_ref  <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_cmp_op    <= C_OP_NONE;
            r_cmp_a     <= '0;
            r_cmp_b     <= '0;
            r_max       <= C_QNAN;
            r_min       <= C_QNAN;
            r_max_idx   <= '0;
            r_min_idx   <= '0;
            r_nan_err   <= 1'b0;
            r_cmp_err   <= 1'b0;
        end else begin
            // Compare request is a registered pulse; only the two compare
            // states re-arm it. Operands hold their last value otherwise.
            r_cmp_valid <= 1'b0;
            r_cmp_op    <= C_OP_NONE;

            case (r_state)
                C_IDLE: begin
                    if (i_start) begin
                        r_len      <= i_len;
                        r_cnt      <= '0;
                        r_have_ref <= 1'b0;
                        r_nan_err  <= 1'b0;
                        r_cmp_err  <= 1'b0;
                        r_max      <= C_QNAN;
                        r_min      <= C_QNAN;
                        r_max_idx  <= '0;
                        r_min_idx  <= '0;
                        r_state    <= (i_len == '0) ? C_DONE : C_FETCH;
                    end
                end

                C_FETCH: begin
                    if (i_data_valid) begin
                        r_elem     <= i_data;
                        r_elem_idx <= r_cnt;
                        r_cnt      <= w_cnt_inc;
                        if (w_elem_nan) begin
                            // NaN elements never reach the compare unit.
                            r_nan_err <= 1'b1;
                            r_state   <= w_last_fetch ? C_DONE : C_FETCH;
                        end else if (!r_have_ref) begin
                            // First ordinary element seeds both extrema.
                            r_max      <= i_data;
                            r_min      <= i_data;
                            r_max_idx  <= r_cnt;
                            r_min_idx  <= r_cnt;
                            r_have_ref <= 1'b1;
                            r_state    <= w_last_fetch ? C_DONE : C_FETCH;
                        end else begin
                            // Issue GT now so it is on the bus in CMP_MAX.
                            r_cmp_valid <= 1'b1;
                            r_cmp_op    <= C_OP_GT;
                            r_cmp_a     <= i_data;
                            r_cmp_b     <= r_max;
                            r_state     <= C_CMP_MAX;
                        end
                    end
                end

                C_CMP_MAX: begin
                    // Min is already final for this element, so LT can go out
                    // while the GT result is still on its way back.
                    r_cmp_valid <= 1'b1;
                    r_cmp_op    <= C_OP_LT;
                    r_cmp_a     <= r_elem;
                    r_cmp_b     <= r_min;
                    r_state     <= C_CMP_MIN;
                end

                C_CMP_MIN: begin
                    // GT result for the request issued in CMP_MAX.
                    r_nan_err <= r_nan_err | i_cmp_nan_err;
                    if (!i_cmp_result_valid) begin
                        r_cmp_err <= 1'b1;
                    end else if (i_cmp_result) begin
                        r_max     <= r_elem;
                        r_max_idx <= r_elem_idx;
                    end
                    r_state <= C_WAIT_MIN;
                end

                C_WAIT_MIN: begin
                    // LT result for the request issued in CMP_MIN.
                    r_nan_err <= r_nan_err | i_cmp_nan_err;
                    if (!i_cmp_result_valid) begin
                        r_cmp_err <= 1'b1;
                    end else if (i_cmp_result) begin
                        r_min     <= r_elem;
                        r_min_idx <= r_elem_idx;
                    end
                    r_state <= (r_cnt == r_len) ? C_DONE : C_FETCH;
                end

                C_DONE: begin
                    if (!r_have_ref) begin
                        r_max     <= C_QNAN;
                        r_min     <= C_QNAN;
                        r_max_idx <= '0;
                        r_min_idx <= '0;
                    end
                    r_state <= C_IDLE;
                end

                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_maxmin_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp32_maxmin_ctrl
//  Purpose  : Self-checking bench for fp32_maxmin_ctrl with a behavioural
//             compare-unit model and an extrema reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp32_maxmin_ctrl;

    localparam int          LEN_W  = 16;
    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             i_start = 1'b0;
    logic [LEN_W-1:0] i_len = '0;
    logic             i_data_valid = 1'b0;
    logic [31:0]      i_data = '0;
    logic             o_data_ready, o_busy, o_cmp_valid, o_done;
    logic [2:0]       o_cmp_op;
    logic [31:0]      o_cmp_a, o_cmp_b, o_max, o_min;
    logic [LEN_W-1:0] o_max_idx, o_min_idx;
    logic             o_nan_err, o_cmp_err;
    logic             cr_valid = 1'b0, cr_res = 1'b0, cr_nan = 1'b0;

    fp32_maxmin_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_len(i_len),
        .i_data_valid(i_data_valid), .i_data(i_data), .o_data_ready(o_data_ready),
        .o_busy(o_busy), .o_cmp_valid(o_cmp_valid), .o_cmp_op(o_cmp_op),
        .o_cmp_a(o_cmp_a), .o_cmp_b(o_cmp_b), .i_cmp_result_valid(cr_valid),
        .i_cmp_result(cr_res), .i_cmp_nan_err(cr_nan), .o_done(o_done),
        .o_max(o_max), .o_min(o_min), .o_max_idx(o_max_idx), .o_min_idx(o_min_idx),
        .o_nan_err(o_nan_err), .o_cmp_err(o_cmp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Total order on non-NaN FP32: sign-magnitude to signed integer, +0 == -0.
    function automatic int fkey(input logic [31:0] v);
        int m;
        m = int'({1'b0, v[30:0]});
        return v[31] ? -m : m;
    endfunction

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // ---------------- compare unit model (1-cycle registered) --------------
    int gt_cnt = 0;
    int gt_base = 0;
    int drop_gt = -1;
    bit inj_nan = 1'b0;
    always @(posedge clk) begin
        if (!rstn) begin
            cr_valid <= 1'b0;
            cr_res   <= 1'b0;
            cr_nan   <= 1'b0;
        end else begin
            cr_valid <= o_cmp_valid && !(o_cmp_op == 3'd1 && (gt_cnt - gt_base) == drop_gt);
            cr_res   <= (o_cmp_op == 3'd1) ? (fkey(o_cmp_a) > fkey(o_cmp_b))
                                           : (fkey(o_cmp_a) < fkey(o_cmp_b));
            cr_nan   <= o_cmp_valid && inj_nan;
            if (o_cmp_valid && o_cmp_op == 3'd1) gt_cnt <= gt_cnt + 1;
        end
    end

    // ---------------- reference model ---------------------------------------
    logic [31:0] el[$];

    // Extrema over el[0 .. upto-1]; the drop_gt-th compared element gets no
    // max update because its GT result never arrives.
    function automatic void model(input int upto, output logic [31:0] mx, output int mxi,
                                  output logic [31:0] mn, output int mni,
                                  output int ncmp, output bit nan);
        bit have;
        have = 1'b0; ncmp = 0; nan = 1'b0;
        mx = C_QNAN; mn = C_QNAN; mxi = 0; mni = 0;
        for (int i = 0; i < upto; i++) begin
            if (is_nan(el[i])) begin
                nan = 1'b1;
            end else if (!have) begin
                have = 1'b1; mx = el[i]; mn = el[i]; mxi = i; mni = i;
            end else begin
                if (ncmp != drop_gt && fkey(el[i]) > fkey(mx)) begin mx = el[i]; mxi = i; end
                if (fkey(el[i]) < fkey(mn)) begin mn = el[i]; mni = i; end
                ncmp++;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl"}, {o_busy, o_done, o_data_ready, o_cmp_valid, o_nan_err, o_cmp_err, o_cmp_op}, 64'd0);
        chk({tag, "_max"}, o_max, C_QNAN);
        chk({tag, "_min"}, o_min, C_QNAN);
        chk({tag, "_idx"}, {o_max_idx, o_min_idx}, 64'd0);
        chk({tag, "_ab"},  {o_cmp_a, o_cmp_b}, 64'd0);
    endtask

    // ---------------- per-cycle monitor state --------------------------------
    logic [31:0] mon_elem = '0, mon_bmax = '0, mon_bmin = '0;
    bit          mon_nan = 1'b0;

    task automatic run_job(input int n, input int stall_pct, input int drp, input bit nan_inj,
                           input bit busy_start, input int rst_at, output int done_cyc);
        int idx = 0, stalls = 0, s, t = 0, mxi, mni, nc;
        logic [31:0] mx, mn;
        bit nn, did_rst = 1'b0;
        done_cyc = -1;
        @(negedge clk);
        drop_gt = drp; inj_nan = nan_inj; gt_base = gt_cnt;
        i_start = 1'b1; i_len = LEN_W'(n); i_data_valid = 1'b0; s = cyc;
        while (t < 3000) begin
            @(negedge clk); t++;
            i_start = 1'b0; i_data_valid = 1'b0;
            if (o_done) begin done_cyc = cyc - s; break; end
            if (busy_start && t == 3) begin i_start = 1'b1; i_len = '0; end
            if (rst_at >= 0 && idx == rst_at + 1 && o_cmp_valid && o_cmp_op == 3'd3) begin
                rstn = 1'b0; did_rst = 1'b1; break;
            end
            if (o_data_ready && idx < n) begin
                if ($urandom_range(99) < stall_pct) stalls++;
                else begin
                    model(idx, mon_bmax, mxi, mon_bmin, mni, nc, nn);
                    i_data_valid = 1'b1; i_data = el[idx];
                    mon_elem = el[idx]; mon_nan = is_nan(el[idx]);
                    idx++;
                end
            end
        end
        if (did_rst) begin
            @(negedge clk);
            chk_reset_vals("midjob_reset");
            rstn = 1'b1;
            done_cyc = -2;
        end else if (done_cyc < 0) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_3000_cycles");
        end else begin
            model(n, mx, mxi, mn, mni, nc, nn);
            chk("done_cycle", done_cyc, 1 + n + 3 * nc + stalls);
            chk("max", o_max, mx);
            chk("min", o_min, mn);
            chk("max_idx", o_max_idx, mxi);
            chk("min_idx", o_min_idx, mni);
            chk("nan_err", o_nan_err, nn || (nan_inj && nc > 0));
            chk("cmp_err", o_cmp_err, drp >= 0 && drp < nc);
            @(negedge clk);
            chk("done_pulse", {o_done, o_busy}, 64'd0);
            chk("max_hold", o_max, mx);
        end
        drop_gt = -1; inj_nan = 1'b0;
    endtask

    function automatic logic [31:0] rnd_elem();
        logic [31:0] pool [8];
        int r;
        pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                 32'h7F800000, 32'hFF800000, 32'h40400000, 32'h00000001};
        r = $urandom_range(99);
        if (r < 8) return {1'($urandom_range(1)), 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
        if (r < 45) return pool[$urandom_range(7)];
        return {1'($urandom_range(1)), 8'($urandom_range(254)), 23'($urandom)};
    endfunction

    initial begin
        int dc, n;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rstn = 1'b1;
        fork
            forever begin
                @(negedge clk);
                if (rstn) begin
                    if (o_cmp_valid) begin
                        chk("cmp_op_legal", o_cmp_op == 3'd1 || o_cmp_op == 3'd3, 64'd1);
                        chk("cmp_a", o_cmp_a, mon_elem);
                        chk("cmp_b", o_cmp_b, (o_cmp_op == 3'd1) ? mon_bmax : mon_bmin);
                        chk("cmp_on_nan_elem", mon_nan, 64'd0);
                    end else begin
                        chk("cmp_op_idle", o_cmp_op, 64'd0);
                    end
                    if (o_data_ready) chk("ready_implies_busy", o_busy, 64'd1);
                end
            end
        join_none

        el = '{32'h3F800000, 32'hC0000000, 32'h40B00000, 32'h3F000000};
        run_job(4, 0, -1, 0, 0, -1, dc);
        chk("t1_cycle", dc, 14);
        chk("t1_max", {o_max, 16'(o_max_idx)}, {32'h40B00000, 16'd2});
        chk("t1_min", {o_min, 16'(o_min_idx)}, {32'hC0000000, 16'd1});
        chk("t1_err", {o_nan_err, o_cmp_err}, 64'd0);

        el = '{32'h40400000, 32'h40400000, 32'h3F800000, 32'h3F800000};
        run_job(4, 0, -1, 0, 0, -1, dc);
        chk("t2_tie_idx", {o_max_idx, o_min_idx}, {16'd0, 16'd2});

        el = '{32'h7FC00000, 32'h40000000, 32'h3F800000};
        run_job(3, 0, -1, 0, 0, -1, dc);
        chk("t3_nan", o_nan_err, 64'd1);
        chk("t3_max", {o_max, 16'(o_max_idx)}, {32'h40000000, 16'd1});
        chk("t3_min", {o_min, 16'(o_min_idx)}, {32'h3F800000, 16'd2});

        el.delete();
        run_job(0, 0, -1, 0, 0, -1, dc);
        chk("t4_len0_cycle", dc, 1);
        chk("t4_len0_vals", {o_max, o_min}, {C_QNAN, C_QNAN});

        el = '{32'h3F800000, 32'h40A00000, 32'hBF800000, 32'h40000000, 32'h40A00000};
        run_job(5, 0, -1, 0, 1, -1, dc);
        chk("t5_busy_start_max", {o_max, 16'(o_max_idx)}, {32'h40A00000, 16'd1});

        el = '{32'h3F800000, 32'h40400000, 32'h40000000};
        run_job(3, 0, 0, 0, 0, -1, dc);
        chk("t6_drop_err", o_cmp_err, 64'd1);
        chk("t6_drop_max", {o_max, 16'(o_max_idx)}, {32'h40000000, 16'd2});
        chk("t6_drop_min", {o_min, 16'(o_min_idx)}, {32'h3F800000, 16'd0});

        el = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        run_job(4, 0, -1, 0, 0, 2, dc);
        run_job(4, 0, -1, 0, 0, -1, dc);
        chk("t7_after_reset_max", {o_max, 16'(o_max_idx)}, {32'h40800000, 16'd3});

        for (int j = 0; j < 25; j++) begin
            n = $urandom_range(12);
            el.delete();
            for (int i = 0; i < n; i++) el.push_back(rnd_elem());
            run_job(n, 25, ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1,
                    1'($urandom_range(7) == 0), 1'($urandom_range(1)), -1, dc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
